// File: rtl/unary_pkg.sv
// unary_pkg: types and helpers shared by the unary operand serializer.
//   state_t  - serializer FSM states (IDLE, SEND, GAP)
//   u_bits   - unary frame length for a given binary operand width
//   max_int  - larger of two integers, used to size the shared counter
package unary_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int u_bits(input int bin_bits);
        return 1 << bin_bits;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shift register, MSB first.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high clear
//   load  - capture din (takes priority over shift)
//   shift - move contents one place toward the MSB, zero-filling the LSB
//   din   - parallel load value
//   sout  - serial output, the current MSB (a flop output)
// After WIDTH shifts the register is all zeros, so sout idles low between
// frames without any extra gating.
module piso_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = sr[WIDTH-1];

endmodule

// File: rtl/unary_operand_serializer.sv
// unary_operand_serializer: turns a pair of binary operands into two
// thermometer-coded serial frames of U_BITS cycles each, followed by
// GAP_CYCLES idle cycles so a downstream unary multiplier can drain.
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high; aborts any frame in progress
//   a_bin     - binary operand A
//   b_bin     - binary operand B
//   op_valid  - operand pair offered
//   op_ready  - block idle and able to accept an operand pair
//   out_a     - serial unary A (ones first)
//   out_b     - serial unary B (ones first)
//   out_valid - qualifies out_a / out_b
//   busy      - high in SEND and GAP
module unary_operand_serializer
    import unary_pkg::*;
#(
    parameter int BIN_BITS   = 4,
    parameter int GAP_CYCLES = 272
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BIN_BITS-1:0] a_bin,
    input  logic [BIN_BITS-1:0] b_bin,
    input  logic                op_valid,
    output logic                op_ready,
    output logic                out_a,
    output logic                out_b,
    output logic                out_valid,
    output logic                busy
);

    localparam int U_BITS = u_bits(BIN_BITS);
    // One counter serves both SEND and GAP, so it is sized for the longer.
    localparam int CNT_W  = $clog2(max_int(U_BITS, GAP_CYCLES) + 1);

    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(U_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift;
    logic [U_BITS-1:0] therm_a;
    logic [U_BITS-1:0] therm_b;

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign load     = op_ready && op_valid;
    assign shift    = (state == SEND);

    // Thermometer code, frame bit k sits at register bit U_BITS-1-k so that
    // the MSB-first shifter emits bit k in SEND cycle k.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop writes it, so no path can leave it unassigned and infer a latch.
        therm_a = '0;
        therm_b = '0;
        for (int k = 0; k < U_BITS; k++) begin
            therm_a[U_BITS-1-k] = (k < int'(a_bin));
            therm_b[U_BITS-1-k] = (k < int'(b_bin));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        state     <= SEND;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (cnt == SEND_LAST) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The shifters hold the captured operands; they drain to zero by the
    // final SEND edge, which keeps out_a/out_b low whenever out_valid is low.
    piso_shift #(.WIDTH(U_BITS)) u_piso_a (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (therm_a),
        .sout  (out_a)
    );

    piso_shift #(.WIDTH(U_BITS)) u_piso_b (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (therm_b),
        .sout  (out_b)
    );

endmodule
